// File: rtl/upower_ri_sequencer.sv
// rtl/upower_ri_sequencer.sv - multi-cycle control sequencer for the uPower R/I-type ALU datapath
//
// Accepts one instruction word over instr_valid/instr_ready, decodes it and
// walks IDLE -> DECODE -> EXEC (EXEC_CYCLES or longer under stall) -> WB, or
// IDLE -> DECODE -> TRAP for an undecodable word.
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   instr_valid/instr_in     instruction offer; instr_ready high only in IDLE
//   stall                    holds the FSM in EXEC
//   instr_out                captured instruction word for the datapath
//   ALU_OP/ALUSrc/RegDst/XO  decoded controls, driven in EXEC and WB only
//   RegWrite, done           one-cycle pulse in WB
//   illegal                  one-cycle pulse in TRAP
//   retired_count            WB count, wraps (only with UPR_SEQ_PERF_EN)
//   illegal_count            TRAP count, saturates (only with UPR_SEQ_PERF_EN)
//
// Optional macro: UPR_SEQ_PERF_EN enables the performance counters; when it is
// undefined both counter ports are constant 0.

module upower_ri_sequencer #(
  parameter int N           = 32,
  parameter int EXEC_CYCLES = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         instr_valid,
  input  logic [N-1:0] instr_in,
  output logic         instr_ready,
  input  logic         stall,
  output logic [N-1:0] instr_out,
  output logic [3:0]   ALU_OP,
  output logic         ALUSrc,
  output logic         RegDst,
  output logic         XO,
  output logic         RegWrite,
  output logic         done,
  output logic         illegal,
  output logic [31:0]  retired_count,
  output logic [15:0]  illegal_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_TRAP
  } state_t;

  state_t state, next_state;

  logic [3:0] exec_cnt;
  logic [3:0] alu_op_q;
  logic       alu_src_q, reg_dst_q, xo_q;

  logic       dec_legal;
  logic [3:0] dec_op;
  logic       dec_src, dec_dst, dec_xo;

  logic [5:0] opcode;
  logic       oe_bit;
  logic [8:0] xo9;
  logic [9:0] xo10;

  assign opcode = instr_out[31:26];
  assign oe_bit = instr_out[10];
  assign xo9    = instr_out[9:1];
  assign xo10   = instr_out[10:1];

  // Rc (bit 0) is deliberately not examined.
  always_comb begin
    dec_legal = 1'b0;
    dec_op    = 4'b0000;
    dec_src   = 1'b0;
    dec_dst   = 1'b0;
    dec_xo    = 1'b0;
    case (opcode)
      6'd14: begin dec_legal = 1'b1; dec_op = 4'b0010; dec_src = 1'b1; dec_xo = 1'b1; end
      6'd28: begin dec_legal = 1'b1; dec_op = 4'b0000; dec_src = 1'b1; end
      6'd24: begin dec_legal = 1'b1; dec_op = 4'b0001; dec_src = 1'b1; end
      6'd31: begin
        if (!oe_bit && xo9 == 9'd266) begin
          dec_legal = 1'b1; dec_op = 4'b0010; dec_dst = 1'b1; dec_xo = 1'b1;
        end else if (!oe_bit && xo9 == 9'd40) begin
          dec_legal = 1'b1; dec_op = 4'b0110; dec_dst = 1'b1; dec_xo = 1'b1;
        end else if (xo10 == 10'd28) begin
          dec_legal = 1'b1; dec_op = 4'b0000; dec_dst = 1'b1;
        end else if (xo10 == 10'd444) begin
          dec_legal = 1'b1; dec_op = 4'b0001; dec_dst = 1'b1;
        end
      end
      default: dec_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      instr_out <= '0;
      exec_cnt  <= 4'd0;
      alu_op_q  <= 4'b0000;
      alu_src_q <= 1'b0;
      reg_dst_q <= 1'b0;
      xo_q      <= 1'b0;
    end else begin
      state <= next_state;
      if (state == S_IDLE && instr_valid)
        instr_out <= instr_in;
      if (state == S_DECODE && dec_legal) begin
        alu_op_q  <= dec_op;
        alu_src_q <= dec_src;
        reg_dst_q <= dec_dst;
        xo_q      <= dec_xo;
        exec_cnt  <= 4'(EXEC_CYCLES - 1);
      end
      // Counter runs down regardless of stall and parks at zero.
      if (state == S_EXEC && exec_cnt != 4'd0)
        exec_cnt <= exec_cnt - 4'd1;
      // Controls drop back to zero as WB retires, so DECODE always sees zeros.
      if (state == S_WB) begin
        alu_op_q  <= 4'b0000;
        alu_src_q <= 1'b0;
        reg_dst_q <= 1'b0;
        xo_q      <= 1'b0;
      end
    end
  end

  always_comb begin
    next_state  = state;
    instr_ready = 1'b0;
    RegWrite    = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    case (state)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) next_state = S_DECODE;
      end
      S_DECODE: next_state = dec_legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        if (exec_cnt == 4'd0 && !stall) next_state = S_WB;
      end
      S_WB: begin
        RegWrite   = 1'b1;
        done       = 1'b1;
        next_state = S_IDLE;
      end
      S_TRAP: begin
        illegal    = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  assign ALU_OP = alu_op_q;
  assign ALUSrc = alu_src_q;
  assign RegDst = reg_dst_q;
  assign XO     = xo_q;

`ifdef UPR_SEQ_PERF_EN
  logic [31:0] retired_q;
  logic [15:0] illegal_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= 32'd0;
      illegal_q <= 16'd0;
    end else begin
      if (state == S_WB)
        retired_q <= retired_q + 32'd1;
      if (state == S_TRAP && illegal_q != 16'hFFFF)
        illegal_q <= illegal_q + 16'd1;
    end
  end

  assign retired_count = retired_q;
  assign illegal_count = illegal_q;
`else
  assign retired_count = 32'd0;
  assign illegal_count = 16'd0;
`endif

endmodule

// File: tb/tb_upower_ri_sequencer.sv
// tb/tb_upower_ri_sequencer.sv - scoreboard testbench for upower_ri_sequencer
//
// Instance 0 uses EXEC_CYCLES=1, instance 1 uses EXEC_CYCLES=3. Stimulus pushes
// the expected retirement/trap event; the monitor pops it when the DUT shows
// RegWrite/done/illegal. Counter expectations follow UPR_SEQ_PERF_EN.

module tb_upower_ri_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid[2], ready[2], stall[2];
  logic [31:0] instr_in[2], instr_out[2], rcnt[2];
  logic [3:0]  alu_op[2];
  logic        alusrc[2], regdst[2], xo[2], regwrite[2], done[2], illegal[2];
  logic [15:0] icnt[2];

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int          d;
    bit          ill;
    int          cyc;
    logic [3:0]  op;
    bit          src, dst, x;
    int          ex;
    logic [31:0] w;
  } exp_t;

  exp_t q[$];

  int       exec_n[2];
  bit       unstable[2];
  logic [6:0] snap[2];

`ifdef UPR_SEQ_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  upower_ri_sequencer #(.N(32), .EXEC_CYCLES(1)) dut0 (
    .clk(clk), .rst(rst), .instr_valid(valid[0]), .instr_in(instr_in[0]),
    .instr_ready(ready[0]), .stall(stall[0]), .instr_out(instr_out[0]),
    .ALU_OP(alu_op[0]), .ALUSrc(alusrc[0]), .RegDst(regdst[0]), .XO(xo[0]),
    .RegWrite(regwrite[0]), .done(done[0]), .illegal(illegal[0]),
    .retired_count(rcnt[0]), .illegal_count(icnt[0])
  );

  upower_ri_sequencer #(.N(32), .EXEC_CYCLES(3)) dut1 (
    .clk(clk), .rst(rst), .instr_valid(valid[1]), .instr_in(instr_in[1]),
    .instr_ready(ready[1]), .stall(stall[1]), .instr_out(instr_out[1]),
    .ALU_OP(alu_op[1]), .ALUSrc(alusrc[1]), .RegDst(regdst[1]), .XO(xo[1]),
    .RegWrite(regwrite[1]), .done(done[1]), .illegal(illegal[1]),
    .retired_count(rcnt[1]), .illegal_count(icnt[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int d, input bit ill, input int c, input logic [3:0] op,
                      input bit s, input bit r, input bit x, input int ex, input logic [31:0] w);
    exp_t e;
    e.d = d; e.ill = ill; e.cyc = c; e.op = op; e.src = s; e.dst = r; e.x = x; e.ex = ex; e.w = w;
    q.push_back(e);
  endtask

  // Called and returns at posedge+1; a = cycle in which the handshake is seen.
  task automatic send(input int d, input logic [31:0] w, input bit hold, output int a);
    bit got = 1'b0;
    valid[d] = 1'b1;
    instr_in[d] = w;
    a = cyc;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (valid[d] && ready[d]) begin
        a = cyc;
        got = 1'b1;
        break;
      end
    end
    if (!got) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    if (!hold) valid[d] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    check("queue_drained", 64'(q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input int d, input string tag);
    check({tag, "_ready"}, 64'(ready[d]), 64'd1);
    check({tag, "_instr_out"}, 64'(instr_out[d]), 64'd0);
    check({tag, "_ctrl"}, 64'({alu_op[d], alusrc[d], regdst[d], xo[d]}), 64'd0);
    check({tag, "_pulses"}, 64'({regwrite[d], done[d], illegal[d]}), 64'd0);
    check({tag, "_counters"}, 64'({rcnt[d], icnt[d]}), 64'd0);
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        exec_n[d] = 0;
        unstable[d] = 1'b0;
      end else begin
        if (regwrite[d] === 1'b1 || illegal[d] === 1'b1)
          check($sformatf("d%0d_rw_ill_exclusive", d), 64'(regwrite[d] & illegal[d]), 64'd0);
        if ((alusrc[d] === 1'b1 || regdst[d] === 1'b1) && regwrite[d] !== 1'b1) begin
          if (exec_n[d] == 0) snap[d] = {alu_op[d], alusrc[d], regdst[d], xo[d]};
          else if (snap[d] != {alu_op[d], alusrc[d], regdst[d], xo[d]}) unstable[d] = 1'b1;
          exec_n[d]++;
        end
        if (regwrite[d] === 1'b1 || done[d] === 1'b1 || illegal[d] === 1'b1) begin
          if (q.size() == 0) begin
            check($sformatf("d%0d_unexpected_event", d), 64'd1, 64'd0);
          end else begin
            exp_t e;
            e = q.pop_front();
            check($sformatf("d%0d_event_dut", d), 64'(d), 64'(e.d));
            check($sformatf("d%0d_event_cycle", d), 64'(cyc), 64'(e.cyc));
            check($sformatf("d%0d_illegal", d), 64'(illegal[d]), 64'(e.ill));
            check($sformatf("d%0d_done", d), 64'(done[d]), 64'(!e.ill));
            check($sformatf("d%0d_regwrite", d), 64'(regwrite[d]), 64'(!e.ill));
            check($sformatf("d%0d_ctrl", d), 64'({alu_op[d], alusrc[d], regdst[d], xo[d]}),
                  64'({e.op, e.src, e.dst, e.x}));
            check($sformatf("d%0d_exec_cycles", d), 64'(exec_n[d]), 64'(e.ex));
            check($sformatf("d%0d_exec_stable", d), 64'(unstable[d]), 64'd0);
            check($sformatf("d%0d_instr_out", d), 64'(instr_out[d]), 64'(e.w));
          end
          exec_n[d] = 0;
          unstable[d] = 1'b0;
        end
      end
    end
  end

  initial begin
    int a, b;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      valid[d] = 1'b0; stall[d] = 1'b0; instr_in[d] = 32'd0;
      exec_n[d] = 0; unstable[d] = 1'b0; snap[d] = 7'd0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero(0, "reset0");
    check_zero(1, "reset1");
    @(posedge clk);
    #1 rst = 1'b0;

    // add R16,R0,R1
    send(0, 32'h7E000A14, 1'b0, a);
    push(0, 1'b0, a + 3, 4'b0010, 1'b0, 1'b1, 1'b1, 1, 32'h7E000A14);
    @(negedge clk);
    check("decode_ready", 64'(ready[0]), 64'd0);
    check("decode_ctrl", 64'({alu_op[0], alusrc[0], regdst[0], xo[0]}), 64'd0);
    repeat (3) @(negedge clk);
    check("ready_after_wb", 64'(ready[0]), 64'd1);
    @(posedge clk);
    #1;

    // addi then andi. with valid held
    send(0, 32'h3A200014, 1'b1, a);
    push(0, 1'b0, a + 3, 4'b0010, 1'b1, 1'b0, 1'b1, 1, 32'h3A200014);
    send(0, 32'h70D60000, 1'b0, b);
    push(0, 1'b0, b + 3, 4'b0000, 1'b1, 1'b0, 1'b0, 1, 32'h70D60000);
    check("back_to_back_spacing", 64'(b - a), 64'd4);
    idle(4);

    // and R0,R0,R0 with Rc=1
    send(0, 32'h7C000039, 1'b0, a);
    push(0, 1'b0, a + 3, 4'b0000, 1'b0, 1'b1, 1'b0, 1, 32'h7C000039);
    idle(4);

    // subf R21,R8,R9 with stall for 5 EXEC cycles
    send(0, 32'h7EA84850, 1'b0, a);
    push(0, 1'b0, a + 8, 4'b0110, 1'b0, 1'b1, 1'b1, 6, 32'h7EA84850);
    @(posedge clk);
    #1 stall[0] = 1'b1;
    repeat (5) @(posedge clk);
    #1 stall[0] = 1'b0;
    idle(3);

    // all-zero word and add with OE=1 both trap
    send(0, 32'h00000000, 1'b0, a);
    push(0, 1'b1, a + 2, 4'b0000, 1'b0, 1'b0, 1'b0, 0, 32'h00000000);
    idle(3);
    send(0, 32'h7E000E14, 1'b0, a);
    push(0, 1'b1, a + 2, 4'b0000, 1'b0, 1'b0, 1'b0, 0, 32'h7E000E14);
    idle(3);
    drain();
    check("d0_retired_count", 64'(rcnt[0]), PERF ? 64'd5 : 64'd0);
    check("d0_illegal_count", 64'(icnt[0]), PERF ? 64'd2 : 64'd0);

    // reset during EXEC of add aborts it
    send(0, 32'h7E000A14, 1'b0, a);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_zero(0, "abort");
    // reset together with a valid offer accepts nothing
    @(posedge clk);
    #1;
    rst = 1'b1; valid[0] = 1'b1; instr_in[0] = 32'h7E000A14;
    @(posedge clk);
    #1;
    rst = 1'b0; valid[0] = 1'b0;
    @(negedge clk);
    check_zero(0, "rst_valid");
    idle(4);

    // EXEC_CYCLES=3: or R24,R6,R7 twice
    send(1, 32'h7CD83B78, 1'b0, a);
    push(1, 1'b0, a + 5, 4'b0001, 1'b0, 1'b1, 1'b0, 3, 32'h7CD83B78);
    idle(6);
    send(1, 32'h7CD83B78, 1'b0, a);
    push(1, 1'b0, a + 5, 4'b0001, 1'b0, 1'b1, 1'b0, 3, 32'h7CD83B78);
    idle(6);
    drain();
    check("d1_retired_count", 64'(rcnt[1]), PERF ? 64'd2 : 64'd0);
    check("d1_illegal_count", 64'(icnt[1]), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
